// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter
// Shares one downstream stream consumer between NUM_REQ FIFO read ports.
// A non-empty FIFO is picked round-robin and receives up to BURST_MAX pops.
// Returned words go into a 2-entry in-order output buffer and leave on a
// valid/ready stream, tagged with the index of the FIFO that supplied them.
//
// Build option: define FIFO_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed priority (index 0 highest). Burst and credit behaviour are the same
// in both builds.
module fifo_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_empty,
    input  logic [NUM_REQ-1:0]            req_almost_empty,
    output logic [NUM_REQ-1:0]            req_rd_en,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rd_data,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_REQ)-1:0]    out_src,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int         IDX_W     = $clog2(NUM_REQ);
    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       grant;
    logic [IDX_W-1:0]       grant_nxt;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       rr_ptr_nxt;
    logic [7:0]             cnt;
    logic [7:0]             cnt_nxt;
    logic                   pop;
    logic                   pop_last;
    logic                   credit_ok;
    logic                   xfer;

    logic                   vld_p1;
    logic [IDX_W-1:0]       src_p1;

    logic [DATA_WIDTH-1:0]  rd_slice [NUM_REQ];
    logic [DATA_WIDTH-1:0]  buf_data [2];
    logic [IDX_W-1:0]       buf_src  [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             occ;

    // Pop counter increment that holds at the burst limit.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= BURST_LIM) ? BURST_LIM : v + 8'd1;
    endfunction

`ifdef FIFO_ARB_FIXED_PRIO_EN
    // Lowest-index non-empty FIFO wins.
    function automatic logic [IDX_W-1:0] pick_fixed(input logic [NUM_REQ-1:0] empty);
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] cand;
        sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'(i);
            if (!empty[cand]) begin
                sel = cand;
            end
        end
        return sel;
    endfunction
`else
    // First non-empty FIFO strictly after ptr, wrapping NUM_REQ-1 -> 0.
    function automatic logic [IDX_W-1:0] pick_rr(input logic [NUM_REQ-1:0] empty,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] cand;
        logic             found;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && !empty[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction
`endif

    // ---- stage p0: arbitration, credit check and pop issue ----

    assign xfer = out_valid && out_ready;

    // A pop is safe when the words already buffered or in flight, minus the
    // one leaving this cycle, still leave a free buffer slot on landing.
    assign credit_ok = ({1'b0, occ} + {2'b00, vld_p1}) < (3'd2 + {2'b00, xfer});

    // Next-state, grant selection and pop decision.
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        cnt_nxt    = cnt;
        rr_ptr_nxt = rr_ptr;
        pop        = 1'b0;
        pop_last   = 1'b0;
        case (state)
            IDLE: begin
                if (req_empty != {NUM_REQ{1'b1}}) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
                    grant_nxt = pick_fixed(req_empty);
`else
                    grant_nxt = pick_rr(req_empty, rr_ptr);
`endif
                    cnt_nxt   = 8'd0;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                // Exiting on a last-flagged pop means a second pop can never
                // follow one issued while the FIFO held its final word.
                if (credit_ok && !req_empty[grant] && (cnt < BURST_LIM)) begin
                    pop      = 1'b1;
                    pop_last = req_almost_empty[grant];
                    cnt_nxt  = sat_inc(cnt);
                end
                if ((cnt_nxt == BURST_LIM) || pop_last || (req_empty[grant] && !pop)) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                rr_ptr_nxt = grant;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pop strobe to the granted FIFO only.
    always_comb begin
        req_rd_en        = '0;
        req_rd_en[grant] = pop;
    end

    // Arbiter control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            grant  <= '0;
            cnt    <= 8'd0;
            rr_ptr <= IDX_W'(NUM_REQ - 1);
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            cnt    <= cnt_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // ---- stage p1: FIFO read data returns one cycle after the pop ----

    // In-flight marker for the pop issued last cycle; cleared by reset so a
    // read interrupted by reset is discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            src_p1 <= '0;
        end else begin
            vld_p1 <= pop;
            src_p1 <= grant;
        end
    end

    // Split the flat read-data bus into per-FIFO words.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_slice[i] = req_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Output buffer pointers and occupancy; push and pop together cancel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (vld_p1) begin
                wr_ptr <= ~wr_ptr;
            end
            if (xfer) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, vld_p1} - {1'b0, xfer};
        end
    end

    // Output buffer storage; contents only matter while occ says so.
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            buf_data[wr_ptr] <= rd_slice[src_p1];
            buf_src[wr_ptr]  <= src_p1;
        end
    end

    // ---- stream output from the buffer head ----

    assign out_valid = (occ != 2'd0);
    assign out_data  = out_valid ? buf_data[rd_ptr] : '0;
    assign out_src   = out_valid ? buf_src[rd_ptr]  : '0;
    assign busy      = (state != IDLE) || (occ != 2'd0) || vld_p1;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Testbench for fifo_rd_arbiter: FIFO bank environment, behavioural
// arbitration model and stream scoreboard.
module tb_fifo_rd_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int BURST_MAX  = 4;
    localparam int IDX_W      = $clog2(NUM_REQ);

    logic                          clk = 1'b0;
    logic                          reset;
    logic [NUM_REQ-1:0]            req_empty;
    logic [NUM_REQ-1:0]            req_almost_empty;
    logic [NUM_REQ-1:0]            req_rd_en;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_rd_data;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [IDX_W-1:0]              out_src;
    logic                          out_valid;
    logic                          out_ready;
    logic                          busy;

    int                    n_tests = 0;
    int                    n_fail  = 0;

    logic [DATA_WIDTH-1:0] fq [NUM_REQ][$];
    int unsigned           exp_q[$];
    int                    exp_b[$];
    int                    pop_log[$];
    int                    pops_total;
    int                    xfers_total;
    bit                    stream_on;
    bit                    prev_stall;
    int unsigned           prev_word;
    bit                    last_pop_ae;

    always #5 clk = ~clk;

    fifo_rd_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_empty       (req_empty),
        .req_almost_empty(req_almost_empty),
        .req_rd_en       (req_rd_en),
        .req_rd_data     (req_rd_data),
        .out_data        (out_data),
        .out_src         (out_src),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    task automatic update_flags();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_empty[i]        = (fq[i].size() == 0);
            req_almost_empty[i] = (fq[i].size() == 1);
        end
    endtask

    task automatic load(input int idx, input int n);
        for (int j = 0; j < n; j++) begin
            fq[idx].push_back(DATA_WIDTH'($urandom));
        end
        update_flags();
    endtask

    // Reference: with all FIFO contents known up front, the output order is
    // fixed: pick a FIFO by the arbitration rule, take min(BURST_MAX, left)
    // words from it, repeat until everything is taken.
    task automatic build_model();
        int left[NUM_REQ];
        int pos[NUM_REQ];
        int rr;
        int g;
        int n;
        int c;
        bit done;
        exp_q.delete();
        exp_b.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            left[i] = fq[i].size();
            pos[i]  = 0;
        end
        rr   = NUM_REQ - 1;
        done = 1'b0;
        while (!done) begin
            g = -1;
`ifdef FIFO_ARB_FIXED_PRIO_EN
            for (int i = 0; i < NUM_REQ; i++) begin
                if (g < 0 && left[i] > 0) g = i;
            end
`else
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (rr + k) % NUM_REQ;
                if (g < 0 && left[c] > 0) g = c;
            end
`endif
            if (g < 0) begin
                done = 1'b1;
            end else begin
                n = (left[g] < BURST_MAX) ? left[g] : BURST_MAX;
                for (int j = 0; j < n; j++) begin
                    exp_q.push_back((g << 16) | int'(fq[g][pos[g] + j]));
                end
                pos[g]  += n;
                left[g] -= n;
                exp_b.push_back((g << 8) | n);
                rr = g;
            end
        end
    endtask

    // One clock cycle: entered at a falling edge with out_ready already set.
    task automatic step();
        int          p;
        int unsigned w;
        #1;
        p = -1;
        chk("rd_en_onehot", int'($countones(req_rd_en) <= 1), 1);
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rd_en[i]) p = i;
        end
        if (p >= 0) begin
            chk("pop_not_empty", int'(fq[p].size() != 0), 1);
            last_pop_ae = req_almost_empty[p];
        end
        chk("inflight_le2", int'((pops_total - xfers_total) <= 2), 1);
        w = (int'(out_src) << 16) | int'(out_data);
        if (prev_stall) chk("hold_stable", w, prev_word);
        if (out_valid && out_ready) begin
            xfers_total++;
            if (stream_on) begin
                if (exp_q.size() == 0) chk("extra_word", w, 32'hFFFF_FFFF);
                else chk("stream_word", w, exp_q.pop_front());
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = w;
        pop_log.push_back(p);
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
        end
        if (p >= 0) begin
            pops_total++;
            if (fq[p].size() != 0) req_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = fq[p].pop_front();
        end
        update_flags();
        @(negedge clk);
    endtask

    task automatic clear_counts();
        pops_total  = 0;
        xfers_total = 0;
        prev_stall  = 1'b0;
        pop_log.delete();
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_counts();
    endtask

    task automatic run_stream(input int mode, input int budget);
        int cyc;
        int left;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            out_ready = (mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
            step();
            cyc++;
        end
        chk("drain_in_budget", exp_q.size(), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_valid", int'(out_valid), 0);
        left = 0;
        for (int i = 0; i < NUM_REQ; i++) left += fq[i].size();
        chk("fifos_drained", left, 0);
    endtask

    // Group the observed pops into runs (same FIFO, consecutive cycles).
    task automatic check_bursts();
        int runs[$];
        int cur;
        int len;
        cur = -1;
        len = 0;
        foreach (pop_log[k]) begin
            if (cur >= 0 && pop_log[k] == cur) begin
                len++;
            end else begin
                if (cur >= 0) runs.push_back((cur << 8) | len);
                cur = pop_log[k];
                len = (cur >= 0) ? 1 : 0;
            end
        end
        if (cur >= 0) runs.push_back((cur << 8) | len);
        chk("burst_count", runs.size(), exp_b.size());
        for (int i = 0; i < runs.size() && i < exp_b.size(); i++) begin
            chk("burst_shape", runs[i], exp_b[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int guard;
        reset       = 1'b0;
        out_ready   = 1'b0;
        req_rd_data = '0;
        stream_on   = 1'b1;
        clear_counts();
        // FIFO 1 holds A,B,C while reset is held
        fq[1].push_back(8'hA1);
        fq[1].push_back(8'hB2);
        fq[1].push_back(8'hC3);
        update_flags();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_rd_en", int'(req_rd_en), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_src", int'(out_src), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        clear_counts();
        build_model();
        run_stream(0, 100);
        chk("s1_pops", pops_total, 3);
        chk("s1_last_ae", int'(last_pop_ae), 1);
        check_bursts();

        // Reset during the third pop of the second burst
        do_reset();
        load(0, 8);
        load(2, 8);
        build_model();
        out_ready = 1'b1;
        guard = 0;
        while (pops_total < 6 && guard < 100) begin
            step();
            guard++;
        end
        #1;
        chk("pop3_active", int'(req_rd_en), 32'h4);
        reset = 1'b0;
        #1;
        chk("mid_rst_rd_en", int'(req_rd_en), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_data", int'(out_data), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_counts();
        build_model();
        run_stream(0, 200);
        first = -1;
        foreach (pop_log[k]) begin
            if (first < 0 && pop_log[k] >= 0) first = pop_log[k];
        end
        chk("restart_idx0", first, 0);

        // Two FIFOs with 10 words each
        do_reset();
        load(0, 10);
        load(2, 10);
        build_model();
        run_stream(0, 400);
        check_bursts();

        // Consumer stalled: only two words may be fetched
        do_reset();
        load(3, 6);
        build_model();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) step();
        #1;
        chk("stall_pops", pops_total, 2);
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_head", (int'(out_src) << 16) | int'(out_data), exp_q[0]);
        run_stream(0, 200);

        // Single remaining word
        do_reset();
        load(0, 1);
        build_model();
        run_stream(0, 100);
        chk("s4_pops", pops_total, 1);
        check_bursts();

        // Random contents and random back-pressure
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < NUM_REQ; i++) load(i, int'($urandom_range(12)));
            build_model();
            run_stream(1, 800);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
Read-side scheduler that shares one downstream consumer between NUM_REQ independent FIFOs. Picks a non-empty FIFO round-robin and issues up to BURST_MAX pops to it. Collects the returned data into a 2-entry output buffer and presents it on a valid/ready stream tagged with the source index. Sits between a bank of FIFO read ports and a single packet/stream consumer.

Parameters:
NUM_REQ, 4, number of requester FIFOs (2..16)
DATA_WIDTH, 8, FIFO data width in bits
BURST_MAX, 4, max pops per grant before re-arbitration (1..255)

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  asynchronous, active-low; all state cleared while low
req_empty  input  NUM_REQ  per-FIFO empty flag
req_almost_empty  input  NUM_REQ  per-FIFO almost_empty flag (exactly one entry left)
req_rd_en  output  NUM_REQ  per-FIFO pop strobe, at most one bit high
req_rd_data  input  NUM_REQ*DATA_WIDTH  FIFO read data, slice i = FIFO i
out_data  output  DATA_WIDTH  stream data
out_src  output  clog2(NUM_REQ)  index of FIFO that supplied out_data
out_valid  output  1  stream valid
out_ready  input  1  consumer ready
busy  output  1  high when FSM not IDLE or data still buffered

Behaviour:
- Reset values: req_rd_en=0, out_valid=0, out_data=0, out_src=0, busy=0, FSM=IDLE, rr pointer=NUM_REQ-1, burst count=0, buffer occupancy=0, pending=0.
- FIFO read latency is fixed at 1 cycle: data for req_rd_en[i] in cycle N is sampled from slice i in cycle N+1 (pending flag marks this).
- Output buffer: 2-entry FIFO, in-order. out_valid = (occ!=0). Transfer when out_valid && out_ready. out_data/out_src are driven from the head entry and are stable while out_valid && !out_ready.
- Credit rule: issue a pop only if occ + pending - (out_valid&&out_ready) < 2. No buffer overflow under any out_ready pattern. Sustains 1 word/cycle with out_ready held high.
- FSM states:
  IDLE: if any req_empty bit is 0, grant the first non-empty index after rr pointer (wrapping NUM_REQ-1 -> 0), clear count, go to BURST. No pop issued in this cycle.
  BURST: pop granted FIFO g when credit is available, !req_empty[g], and the previous pop in this burst was not flagged last. A pop issued while req_almost_empty[g]=1 is flagged last.
  BURST exit: go to RELEASE when count==BURST_MAX, a last-flagged pop was issued, or req_empty[g]=1 with no pop this cycle.
  RELEASE: one cycle with no pop, letting the pending read land. Set rr pointer=g. Go to IDLE.
- Count is 8-bit, increments per pop, and never exceeds BURST_MAX.
- Back-to-back pops to the same FIFO are allowed only when almost_empty was 0 at the prior pop, because flags update one cycle after rd_en. A pop is never issued to an empty FIFO.
- Simultaneous events:
  - A buffer push (pending data landing) and a pop in the same cycle leave occ unchanged.
  - A FIFO going non-empty during another FIFO's grant does not preempt it.
- Reset asserted mid-burst: pending read data is discarded, the buffer is flushed, out_valid drops asynchronously, and arbitration restarts from index 0 after release.
- busy = (FSM!=IDLE) || occ!=0 || pending.

Optional Feature:
FIFO_ARB_FIXED_PRIO_EN
- Defined: IDLE grants the lowest-index non-empty FIFO (index 0 highest); the rr pointer is unused. Burst and credit rules are unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single FIFO 1 holds 3 words A,B,C, out_ready=1 -> req_rd_en[1] high for 3 cycles; the last pop has almost_empty=1; out stream A,B,C with out_src=1, back-to-back; FSM returns to IDLE, busy=0.
- FIFOs 0 and 2 each hold 10 words, BURST_MAX=4, out_ready=1 -> grant order 0,2,0,2,0,2; bursts of 4,4,4,4,2,2; RELEASE gap of 1 cycle between bursts; no word lost or duplicated.
- FIFO 3 holds 6 words, out_ready held 0 -> exactly 2 pops issued, occ=2, out_data stable. After out_ready=1 the remaining 4 words follow in order; occ never exceeds 2.
- FIFO 0 has 1 word left (almost_empty=1) -> exactly one pop, then RELEASE. No pop is issued while empty=1.
- Reset driven low during the 3rd pop of a burst with occ=1 -> out_valid=0 and req_rd_en=0 immediately. After release, the next grant goes to the lowest non-empty index.
- With FIFO_ARB_FIXED_PRIO_EN defined, FIFOs 1 and 3 non-empty -> FIFO 1 granted every arbitration until empty, then FIFO 3.
